// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, widths and the reorder-buffer entry layout.
package tomasulo_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int PTR_W     = 3;
  localparam int DATA_W    = 8;
  localparam int REG_W     = 4;
  localparam int OP_W      = 4;

  localparam logic [OP_W-1:0] OP_SUB   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL   = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV   = 4'b0011;
  localparam logic [OP_W-1:0] OP_STORE = 4'b0100;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0101;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrapping ROB pointer: increments on enable, synchronous clear, async reset.
module rob_ptr_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  // Depth is a power of two, so natural overflow gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: allocates at tail, completes by tag, retires the oldest done entry in order.
module rob_retire
  import tomasulo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [OP_W-1:0]   alloc_opcode,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [PTR_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [PTR_W-1:0]  rf_wtag,
  output logic              retire_valid,
  output logic [OP_W-1:0]   retire_opcode,
  output logic [PTR_W:0]    count,
  output logic              empty
);
  localparam int DEPTH = ROB_DEPTH;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  rob_entry_t       rob [DEPTH];
  rob_entry_t       head_e;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count_q;
  logic             do_alloc, do_wb, do_retire;

  assign head_e      = rob[head];
  assign alloc_ready = count_q < FULL;
  assign alloc_tag   = tail;
  assign count       = count_q;
  assign empty       = (count_q == '0);

  // Flush wins over every other action in the same cycle.
  assign do_alloc  = alloc_valid && alloc_ready && !flush;
  assign do_wb     = wb_valid && rob[wb_tag].busy && !rob[wb_tag].done && !flush;
  assign do_retire = head_e.busy && head_e.done && !flush;

  rob_ptr_ctr #(.W(PTR_W)) u_head (
    .clk(clk), .rst(rst), .clr(flush), .inc(do_retire), .ptr(head)
  );

  rob_ptr_ctr #(.W(PTR_W)) u_tail (
    .clk(clk), .rst(rst), .clr(flush), .inc(do_alloc), .ptr(tail)
  );

  // Head and tail only collide when empty or full, so alloc and retire never touch the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob[i].busy <= 1'b0;
        rob[i].done <= 1'b0;
      end
    end else begin
      if (do_wb) begin
        rob[wb_tag].value <= wb_value;
        rob[wb_tag].done  <= 1'b1;
      end
      if (do_retire) rob[head].busy <= 1'b0;
      if (do_alloc) begin
        rob[tail].busy   <= 1'b1;
        rob[tail].done   <= 1'b0;
        rob[tail].opcode <= alloc_opcode;
        rob[tail].dest   <= alloc_dest;
        rob[tail].value  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({do_alloc, do_retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Retire strobes last one cycle; the data fields hold their last retired values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we         <= 1'b0;
      retire_valid  <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      rf_wtag       <= '0;
      retire_opcode <= '0;
    end else if (flush) begin
      rf_we        <= 1'b0;
      retire_valid <= 1'b0;
    end else begin
      rf_we        <= do_retire && (head_e.opcode != OP_STORE);
      retire_valid <= do_retire;
      if (do_retire) begin
        rf_waddr      <= head_e.dest;
        rf_wdata      <= head_e.value;
        rf_wtag       <= head;
        retire_opcode <= head_e.opcode;
      end
    end
  end
endmodule
